idex_hazard_stage: RTL and testbench

//  ID/EX pipeline register with load-use hazard detection and bubble/flush control.

---
 rtl/idex_hazard_stage_pkg.sv | 34 +++
 rtl/idex_hazard_stage_load_use_detect.sv | 33 +++
 rtl/idex_hazard_stage.sv | 183 ++++++++++++++++++
 tb/tb_idex_hazard_stage.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/idex_hazard_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : idex_hazard_stage_pkg
//  Brief    : Shared types and constants for the ID/EX hazard stage.
//  Revision : 1.0 - initial release
// ============================================================================
package idex_hazard_stage_pkg;

    // Stall sequencer states
    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    // Architectural zero register; never a real RAW dependency
    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int unsigned DEFAULT_DATA_W    = 32;
    localparam int unsigned DEFAULT_ALUCTRL_W = 4;

    // Single-bit control fields carried from decode into EX
    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic alu_src;
    } ctrl_t;

    // Control bundle of an injected bubble: no side effects at all
    localparam ctrl_t NOP_CTRL = '0;

endpackage : idex_hazard_stage_pkg
`default_nettype wire

// File: rtl/idex_hazard_stage_load_use_detect.sv
`default_nettype none
// ============================================================================
//  Module   : load_use_detect
//  Brief    : Combinational load-use RAW comparator between the load sitting
//             in ID/EX and the source registers of the instruction in decode.
//  Revision : 1.0 - initial release
// ============================================================================
module load_use_detect
    import idex_hazard_stage_pkg::*;
(
    input  logic       IDEX_Valid,
    input  logic       IDEX_MemRead,
    input  logic [4:0] IDEX_DestReg,
    input  logic [4:0] IFID_RegRs,
    input  logic [4:0] IFID_RegRt,
    input  logic       ID_UsesRt,
    output logic       hazard_o
);

    logic w_is_load;
    logic w_rs_match;
    logic w_rt_match;

    // A load writing r0 produces nothing a consumer could depend on
    assign w_is_load  = IDEX_Valid & IDEX_MemRead & (IDEX_DestReg != REG_ZERO);
    assign w_rs_match = (IDEX_DestReg == IFID_RegRs);
    // Immediate-form instructions carry a destination in the rt field, not a source
    assign w_rt_match = ID_UsesRt & (IDEX_DestReg == IFID_RegRt);

    assign hazard_o   = w_is_load & (w_rs_match | w_rt_match);

endmodule : load_use_detect
`default_nettype wire

// File: rtl/idex_hazard_stage.sv
`default_nettype none
// ============================================================================
//  Module   : idex_hazard_stage
//  Brief    : ID/EX pipeline register with load-use stall sequencing,
//             flush/bubble injection and a saturating stall counter.
//  Revision : 1.0 - initial release
// ============================================================================
module idex_hazard_stage
    import idex_hazard_stage_pkg::*;
#(
    parameter int unsigned DATA_W            = DEFAULT_DATA_W,
    parameter int unsigned ALUCTRL_W         = DEFAULT_ALUCTRL_W,
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned PERF_W            = 16
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           IFID_RegRs,
    input  logic [4:0]           IFID_RegRt,
    input  logic                 ID_UsesRt,
    input  logic [4:0]           ID_DestReg,
    input  logic [DATA_W-1:0]    ID_BusA,
    input  logic [DATA_W-1:0]    ID_BusB,
    input  logic [DATA_W-1:0]    ID_Imm,
    input  logic                 ID_RegWrite,
    input  logic                 ID_MemRead,
    input  logic                 ID_MemWrite,
    input  logic                 ID_MemToReg,
    input  logic                 ID_ALUSrc,
    input  logic [ALUCTRL_W-1:0] ID_ALUCtrl,
    input  logic                 ID_Valid,
    input  logic                 Flush,
    output logic [4:0]           IDEX_RegRs,
    output logic [4:0]           IDEX_RegRt,
    output logic [4:0]           IDEX_DestReg,
    output logic [DATA_W-1:0]    IDEX_BusA,
    output logic [DATA_W-1:0]    IDEX_BusB,
    output logic [DATA_W-1:0]    IDEX_Imm,
    output logic                 IDEX_RegWrite,
    output logic                 IDEX_MemRead,
    output logic                 IDEX_MemWrite,
    output logic                 IDEX_MemToReg,
    output logic                 IDEX_ALUSrc,
    output logic [ALUCTRL_W-1:0] IDEX_ALUCtrl,
    output logic                 IDEX_Valid,
    output logic                 PCWrite,
    output logic                 IFIDWrite,
    output logic [PERF_W-1:0]    Stall_Count
);

    // The first bubble is issued from RUN; STALL covers the remaining ones
    localparam bit          MULTI_STALL = (LOAD_STALL_CYCLES > 1);
    localparam logic [1:0]  CNT_INIT    = MULTI_STALL ? 2'(LOAD_STALL_CYCLES - 2) : 2'd0;
    localparam logic [PERF_W-1:0] SC_MAX = '1;
    localparam logic [PERF_W-1:0] SC_ONE = {{(PERF_W-1){1'b0}}, 1'b1};

    state_t                 state_q, state_d;
    logic [1:0]             cnt_q, cnt_d;
    logic [PERF_W-1:0]      stall_count_q, stall_count_d;

    ctrl_t                  ctrl_q;
    logic                   valid_q;
    logic [4:0]             rs_q, rt_q, dest_q;
    logic [DATA_W-1:0]      busa_q, busb_q, imm_q;
    logic [ALUCTRL_W-1:0]   aluctrl_q;

    logic                   w_hazard;
    logic                   w_stall;
    logic                   w_bubble;
    ctrl_t                  w_id_ctrl;

    load_use_detect u_load_use_detect (
        .IDEX_Valid   (valid_q),
        .IDEX_MemRead (ctrl_q.mem_read),
        .IDEX_DestReg (dest_q),
        .IFID_RegRs   (IFID_RegRs),
        .IFID_RegRt   (IFID_RegRt),
        .ID_UsesRt    (ID_UsesRt),
        .hazard_o     (w_hazard)
    );

    // A redirect kills the consumer anyway, so it overrides any stall
    assign w_stall   = ~Flush & (w_hazard | (state_q == ST_STALL));
    assign w_bubble  = Flush | w_stall;
    assign PCWrite   = ~reset & ~w_stall;
    assign IFIDWrite = ~reset & ~w_stall;

    assign w_id_ctrl = '{reg_write:  ID_RegWrite,
                         mem_read:   ID_MemRead,
                         mem_write:  ID_MemWrite,
                         mem_to_reg: ID_MemToReg,
                         alu_src:    ID_ALUSrc};

    // Stall sequencer next state and remaining-bubble counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (Flush) begin
            state_d = ST_RUN;
            cnt_d   = 2'd0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (w_hazard && MULTI_STALL) begin
                        state_d = ST_STALL;
                        cnt_d   = CNT_INIT;
                    end
                end
                ST_STALL: begin
                    if (cnt_q == 2'd0) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    // Saturating count of hazard bubble cycles
    always_comb begin
        stall_count_d = stall_count_q;
        if (w_stall && (stall_count_q != SC_MAX)) begin
            stall_count_d = stall_count_q + SC_ONE;
        end
    end

    // Sequencer and performance counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_RUN;
            cnt_q         <= 2'd0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    // ID/EX register bank: reset and bubbles both load an all-zero NOP
    always_ff @(posedge clk) begin
        if (reset || w_bubble) begin
            ctrl_q    <= NOP_CTRL;
            valid_q   <= 1'b0;
            rs_q      <= REG_ZERO;
            rt_q      <= REG_ZERO;
            dest_q    <= REG_ZERO;
            busa_q    <= '0;
            busb_q    <= '0;
            imm_q     <= '0;
            aluctrl_q <= '0;
        end else begin
            ctrl_q    <= w_id_ctrl;
            valid_q   <= ID_Valid;
            rs_q      <= IFID_RegRs;
            rt_q      <= IFID_RegRt;
            dest_q    <= ID_DestReg;
            busa_q    <= ID_BusA;
            busb_q    <= ID_BusB;
            imm_q     <= ID_Imm;
            aluctrl_q <= ID_ALUCtrl;
        end
    end

    assign IDEX_RegRs    = rs_q;
    assign IDEX_RegRt    = rt_q;
    assign IDEX_DestReg  = dest_q;
    assign IDEX_BusA     = busa_q;
    assign IDEX_BusB     = busb_q;
    assign IDEX_Imm      = imm_q;
    assign IDEX_RegWrite = ctrl_q.reg_write;
    assign IDEX_MemRead  = ctrl_q.mem_read;
    assign IDEX_MemWrite = ctrl_q.mem_write;
    assign IDEX_MemToReg = ctrl_q.mem_to_reg;
    assign IDEX_ALUSrc   = ctrl_q.alu_src;
    assign IDEX_ALUCtrl  = aluctrl_q;
    assign IDEX_Valid    = valid_q;
    assign Stall_Count   = stall_count_q;

endmodule : idex_hazard_stage
`default_nettype wire

// File: tb/tb_idex_hazard_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_idex_hazard_stage
//  Brief    : Self-checking bench; three instances share stimulus:
//             [0] 1-cycle stall, [1] 3-cycle stall, [2] 4-bit stall counter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_idex_hazard_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [4:0]  rs, rt, dest;
    logic        uses;
    logic [31:0] busa, busb, imm;
    logic        rw, mr, mw, m2r, asrc;
    logic [3:0]  aluc;
    logic        valid, flush;

    logic [4:0]  o_rs   [3];
    logic [4:0]  o_rt   [3];
    logic [4:0]  o_dest [3];
    logic [31:0] o_busa [3];
    logic [31:0] o_busb [3];
    logic [31:0] o_imm  [3];
    logic        o_rw   [3];
    logic        o_mr   [3];
    logic        o_mw   [3];
    logic        o_m2r  [3];
    logic        o_as   [3];
    logic [3:0]  o_alu  [3];
    logic        o_v    [3];
    logic        o_pc   [3];
    logic        o_ifid [3];
    logic [15:0] o_sc   [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned LSC = (g == 1) ? 3 : 1;
        localparam int unsigned PW  = (g == 2) ? 4 : 16;
        logic [PW-1:0] sc;
        idex_hazard_stage #(
            .DATA_W(32), .ALUCTRL_W(4), .LOAD_STALL_CYCLES(LSC), .PERF_W(PW)
        ) u_dut (
            .clk(clk), .reset(reset),
            .IFID_RegRs(rs), .IFID_RegRt(rt), .ID_UsesRt(uses), .ID_DestReg(dest),
            .ID_BusA(busa), .ID_BusB(busb), .ID_Imm(imm),
            .ID_RegWrite(rw), .ID_MemRead(mr), .ID_MemWrite(mw),
            .ID_MemToReg(m2r), .ID_ALUSrc(asrc), .ID_ALUCtrl(aluc),
            .ID_Valid(valid), .Flush(flush),
            .IDEX_RegRs(o_rs[g]), .IDEX_RegRt(o_rt[g]), .IDEX_DestReg(o_dest[g]),
            .IDEX_BusA(o_busa[g]), .IDEX_BusB(o_busb[g]), .IDEX_Imm(o_imm[g]),
            .IDEX_RegWrite(o_rw[g]), .IDEX_MemRead(o_mr[g]), .IDEX_MemWrite(o_mw[g]),
            .IDEX_MemToReg(o_m2r[g]), .IDEX_ALUSrc(o_as[g]), .IDEX_ALUCtrl(o_alu[g]),
            .IDEX_Valid(o_v[g]), .PCWrite(o_pc[g]), .IFIDWrite(o_ifid[g]),
            .Stall_Count(sc)
        );
        assign o_sc[g] = 16'(sc);
    end

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [4:0]  rs, rt, dest;
        logic        uses, rw, mr, valid, flush;
        logic [31:0] a;
    } vin_t;

    typedef struct {
        vin_t        in;
        logic        epc, ev, emr, erw;
        logic [4:0]  edst;
        logic [31:0] ea;
        logic [15:0] esc;
    } vec_t;

    function automatic vin_t mi(logic [4:0] rs_, logic [4:0] rt_, logic u_, logic [4:0] d_,
                                logic [31:0] a_, logic rw_, logic mr_, logic v_, logic f_);
        vin_t r;
        r.rs = rs_; r.rt = rt_; r.uses = u_; r.dest = d_; r.a = a_;
        r.rw = rw_; r.mr = mr_; r.valid = v_; r.flush = f_;
        return r;
    endfunction

    function automatic vec_t mv(vin_t i_, logic pc_, logic v_, logic mr_, logic rw_,
                                logic [4:0] d_, logic [31:0] a_, logic [15:0] sc_);
        vec_t r;
        r.in = i_; r.epc = pc_; r.ev = v_; r.emr = mr_; r.erw = rw_;
        r.edst = d_; r.ea = a_; r.esc = sc_;
        return r;
    endfunction

    task automatic drive(input vin_t v);
        rs = v.rs; rt = v.rt; uses = v.uses; dest = v.dest;
        busa = v.a; busb = ~v.a; imm = v.a + 32'd1;
        rw = v.rw; mr = v.mr; mw = 1'b0; m2r = v.mr; asrc = v.mr;
        aluc = v.a[3:0]; valid = v.valid; flush = v.flush;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic rst_all();
        @(negedge clk);
        reset = 1'b1;
        drive(mi(5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    vin_t lw5, dep5;
    vec_t vec [15];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        lw5  = mi(5'd1, 5'd0, 1'b0, 5'd5, 32'h0000_0011, 1'b1, 1'b1, 1'b1, 1'b0);
        dep5 = mi(5'd5, 5'd2, 1'b1, 5'd6, 32'h0000_0022, 1'b1, 1'b0, 1'b1, 1'b0);

        //           rs     rt     u     dest   data            rw    mr    v     fl        pc    v     mr    rw    dest   expected A      count
        vec[0]  = mv(mi(5'd1, 5'd2, 1'b1, 5'd3,  32'hA000_0001, 1'b1, 1'b0, 1'b1, 1'b0), 1'b1, 1'b1, 1'b0, 1'b1, 5'd3,  32'hA000_0001, 16'd0);
        vec[1]  = mv(mi(5'd1, 5'd0, 1'b0, 5'd5,  32'hB000_0005, 1'b1, 1'b1, 1'b1, 1'b0), 1'b1, 1'b1, 1'b1, 1'b1, 5'd5,  32'hB000_0005, 16'd0);
        vec[2]  = mv(mi(5'd5, 5'd2, 1'b1, 5'd6,  32'hC000_0006, 1'b1, 1'b0, 1'b1, 1'b0), 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,         16'd1);
        vec[3]  = mv(mi(5'd5, 5'd2, 1'b1, 5'd6,  32'hC000_0006, 1'b1, 1'b0, 1'b1, 1'b0), 1'b1, 1'b1, 1'b0, 1'b1, 5'd6,  32'hC000_0006, 16'd1);
        vec[4]  = mv(mi(5'd1, 5'd0, 1'b0, 5'd0,  32'hD000_0000, 1'b1, 1'b1, 1'b1, 1'b0), 1'b1, 1'b1, 1'b1, 1'b1, 5'd0,  32'hD000_0000, 16'd1);
        vec[5]  = mv(mi(5'd0, 5'd0, 1'b1, 5'd8,  32'hE000_0008, 1'b1, 1'b0, 1'b1, 1'b0), 1'b1, 1'b1, 1'b0, 1'b1, 5'd8,  32'hE000_0008, 16'd1);
        vec[6]  = mv(mi(5'd1, 5'd0, 1'b0, 5'd7,  32'hF000_0007, 1'b1, 1'b1, 1'b1, 1'b0), 1'b1, 1'b1, 1'b1, 1'b1, 5'd7,  32'hF000_0007, 16'd1);
        vec[7]  = mv(mi(5'd1, 5'd7, 1'b0, 5'd9,  32'h1000_0019, 1'b1, 1'b0, 1'b1, 1'b0), 1'b1, 1'b1, 1'b0, 1'b1, 5'd9,  32'h1000_0019, 16'd1);
        vec[8]  = mv(mi(5'd1, 5'd0, 1'b0, 5'd7,  32'h2000_0027, 1'b1, 1'b1, 1'b1, 1'b0), 1'b1, 1'b1, 1'b1, 1'b1, 5'd7,  32'h2000_0027, 16'd1);
        vec[9]  = mv(mi(5'd1, 5'd7, 1'b1, 5'd10, 32'h3000_003A, 1'b1, 1'b0, 1'b1, 1'b0), 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,         16'd2);
        vec[10] = mv(mi(5'd1, 5'd7, 1'b1, 5'd10, 32'h3000_003A, 1'b1, 1'b0, 1'b1, 1'b0), 1'b1, 1'b1, 1'b0, 1'b1, 5'd10, 32'h3000_003A, 16'd2);
        vec[11] = mv(mi(5'd1, 5'd0, 1'b0, 5'd4,  32'h4000_0044, 1'b1, 1'b1, 1'b1, 1'b0), 1'b1, 1'b1, 1'b1, 1'b1, 5'd4,  32'h4000_0044, 16'd2);
        vec[12] = mv(mi(5'd4, 5'd0, 1'b0, 5'd11, 32'h5000_005B, 1'b1, 1'b0, 1'b1, 1'b1), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,         16'd2);
        vec[13] = mv(mi(5'd1, 5'd0, 1'b0, 5'd4,  32'h6000_0064, 1'b1, 1'b1, 1'b0, 1'b0), 1'b1, 1'b0, 1'b1, 1'b1, 5'd4,  32'h6000_0064, 16'd2);
        vec[14] = mv(mi(5'd4, 5'd0, 1'b0, 5'd12, 32'h7000_007C, 1'b1, 1'b0, 1'b1, 1'b0), 1'b1, 1'b1, 1'b0, 1'b1, 5'd12, 32'h7000_007C, 16'd2);

        // Reset held two cycles with every decode input asserted
        reset = 1'b1;
        drive(mi(5'd31, 5'd31, 1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b0));
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            chk($sformatf("rst%0d_valid", c), 32'(o_v[0]), 32'd0);
            chk($sformatf("rst%0d_memread", c), 32'(o_mr[0]), 32'd0);
            chk($sformatf("rst%0d_regwrite", c), 32'(o_rw[0]), 32'd0);
            chk($sformatf("rst%0d_dest", c), 32'(o_dest[0]), 32'd0);
            chk($sformatf("rst%0d_busa", c), o_busa[0], 32'd0);
            chk($sformatf("rst%0d_imm", c), o_imm[0], 32'd0);
            chk($sformatf("rst%0d_alu", c), 32'(o_alu[0]), 32'd0);
            chk($sformatf("rst%0d_pcwrite", c), 32'(o_pc[0]), 32'd0);
            chk($sformatf("rst%0d_ifidwrite", c), 32'(o_ifid[0]), 32'd0);
            chk($sformatf("rst%0d_count", c), 32'(o_sc[0]), 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) chk($sformatf("post_rst_pcwrite_dut%0d", d), 32'(o_pc[d]), 32'd1);

        // Directed vector table on the single-bubble instance
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            drive(vec[i].in);
            #1;
            chk($sformatf("v%0d_pcwrite", i), 32'(o_pc[0]), 32'(vec[i].epc));
            chk($sformatf("v%0d_ifidwrite", i), 32'(o_ifid[0]), 32'(vec[i].epc));
            @(posedge clk); #1;
            chk($sformatf("v%0d_valid", i), 32'(o_v[0]), 32'(vec[i].ev));
            chk($sformatf("v%0d_memread", i), 32'(o_mr[0]), 32'(vec[i].emr));
            chk($sformatf("v%0d_regwrite", i), 32'(o_rw[0]), 32'(vec[i].erw));
            chk($sformatf("v%0d_dest", i), 32'(o_dest[0]), 32'(vec[i].edst));
            chk($sformatf("v%0d_busa", i), o_busa[0], vec[i].ea);
            chk($sformatf("v%0d_count", i), 32'(o_sc[0]), 32'(vec[i].esc));
        end

        // Three-bubble stall on instance 1
        rst_all();
        drive(lw5);
        @(posedge clk);
        @(negedge clk);
        drive(dep5);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            chk($sformatf("ms%0d_pcwrite", k), 32'(o_pc[1]), 32'd0);
            @(posedge clk); #1;
            chk($sformatf("ms%0d_valid", k), 32'(o_v[1]), 32'd0);
        end
        @(negedge clk); #1;
        chk("ms_release_pcwrite", 32'(o_pc[1]), 32'd1);
        @(posedge clk); #1;
        chk("ms_dep_valid", 32'(o_v[1]), 32'd1);
        chk("ms_dep_dest", 32'(o_dest[1]), 32'd6);
        chk("ms_dep_busa", o_busa[1], 32'h0000_0022);
        chk("ms_count", 32'(o_sc[1]), 32'd3);

        // Reset in the middle of a three-bubble stall
        @(negedge clk);
        drive(lw5);
        @(posedge clk);
        @(negedge clk);
        drive(dep5);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rms_hold_pcwrite", 32'(o_pc[1]), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rms_after_pcwrite", 32'(o_pc[1]), 32'd1);
        chk("rms_after_count", 32'(o_sc[1]), 32'd0);

        // Flush in the second cycle of a three-bubble stall
        @(negedge clk);
        drive(lw5);
        @(posedge clk);
        @(negedge clk);
        drive(dep5);
        #1;
        chk("fl_stall_pcwrite", 32'(o_pc[1]), 32'd0);
        @(posedge clk); #1;
        chk("fl_bubble1_valid", 32'(o_v[1]), 32'd0);
        @(negedge clk);
        flush = 1'b1;
        #1;
        chk("fl_flush_pcwrite", 32'(o_pc[1]), 32'd1);
        @(posedge clk); #1;
        chk("fl_bubble2_valid", 32'(o_v[1]), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("fl_next_pcwrite", 32'(o_pc[1]), 32'd1);
        @(posedge clk); #1;
        chk("fl_dep_valid", 32'(o_v[1]), 32'd1);
        chk("fl_dep_dest", 32'(o_dest[1]), 32'd6);
        chk("fl_count", 32'(o_sc[1]), 32'd1);

        // Twenty single-bubble hazards: 4-bit counter saturates at 15
        rst_all();
        for (int it = 1; it <= 20; it++) begin
            if (it > 1) @(negedge clk);
            drive(lw5);
            @(posedge clk);
            @(negedge clk);
            drive(dep5);
            @(posedge clk);
            @(negedge clk);
            @(posedge clk); #1;
            if (it == 10) chk("sat_count_at10", 32'(o_sc[2]), 32'd10);
        end
        chk("sat_count_final", 32'(o_sc[2]), 32'd15);
        chk("wide_count_final", 32'(o_sc[0]), 32'd20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_idex_hazard_stage
`default_nettype wire
